instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
- Serial-byte programmer for the Hack instruction memory (1024 x 16).
- Receives a framed image one byte at a time and writes it into instruction memory word by word.
- Holds the Hack CPU in reset while loading, then releases it.
- Sits between the UART receiver and the instruction memory write port, so ROM images can change without re-running memory initialisation.

Parameters:
- ADDR_WIDTH, 10, instruction memory address width; depth = 2**ADDR_WIDTH words.
- HEADER, 8'hA5, frame start byte.
- HOLD_AT_RESET, 0, value of cpu_hold after reset (1 = CPU held until the first good load).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  8  received byte.
- in_valid  input  1  in_data valid this cycle.
- in_ready  output  1  loader accepts a byte this cycle; a byte transfers when in_valid & in_ready.
- wr_en  output  1  one-cycle instruction memory write strobe.
- wr_addr  output  ADDR_WIDTH  write address.
- wr_data  output  16  write data.
- cpu_hold  output  1  drives the Hack CPU reset input.
- loaded  output  1  last frame completed with a good checksum.
- err  output  1  last frame was aborted (bad length or checksum).

Behaviour:
- Reset values:
  - state = IDLE; wr_en = 0; wr_addr = 0; wr_data = 0.
  - cpu_hold = HOLD_AT_RESET; loaded = 0; err = 0.
  - Internal count = 0; len = 0; csum = 0; hi byte = 0.
- Reset asserted mid-frame aborts the frame immediately. Words already written stay in memory.
- in_ready is 1 in every state except WRITE, where it is 0 for exactly one cycle.
- Frame format:
  - HEADER, LEN_H, LEN_L, then N words each sent MSB byte first, then CSUM.
  - N = {LEN_H, LEN_L}.
  - CSUM = XOR of all 2N data bytes; 8'h00 when N = 0.
- State transitions (each on an accepted byte unless noted):
  - IDLE: byte == HEADER → LEN_H; set cpu_hold = 1, clear loaded and err, clear csum and count. Any other byte is discarded.
  - LEN_H: store the byte → LEN_L.
  - LEN_L: form N.
    - N > 2**ADDR_WIDTH → ERROR.
    - N == 0 → CHECK.
    - Otherwise → DATA_H.
  - DATA_H: latch the high byte; csum ^= byte → DATA_L.
  - DATA_L: csum ^= byte; register wr_data = {hi, byte} and wr_addr = count[ADDR_WIDTH-1:0] → WRITE.
  - WRITE (one cycle, unconditional): wr_en = 1; count += 1. If the new count == N → CHECK, else → DATA_H.
  - CHECK: byte == csum → DONE, else → ERROR.
  - DONE (one cycle, unconditional): loaded = 1; cpu_hold = 0 → IDLE.
  - ERROR (one cycle, unconditional): err = 1; cpu_hold stays 1 → IDLE.
- Write timing:
  - The write lands in the cycle after the DATA_L byte is accepted.
  - wr_en is high only in WRITE, exactly one pulse per word.
- Addresses start at 0 every frame and increment by 1.
- N == 2**ADDR_WIDTH is legal: the last word goes to the top address and count does not wrap before the compare.
- A HEADER byte received inside a frame is treated as data, never as a resync.
- After ERROR the CPU stays held until a later frame reaches DONE.
- After DONE, a new HEADER re-asserts cpu_hold in the same cycle the byte is accepted (cpu_hold high the following cycle).
- loaded and err are sticky until the next HEADER in IDLE; they are never both 1.
- in_valid arriving while in_ready = 0 is not consumed; the sender must hold the byte.

Test Plan:
- Reset with HOLD_AT_RESET=0 → cpu_hold=0, loaded=0, err=0, wr_en=0, in_ready=1; bytes 8'h00, 8'h12 in IDLE → no state change, no writes.
- Frame A5 00 02 | 12 34 | AB CD | csum (12^34^AB^CD = 8'h40) →
  - writes {0:16'h1234, 1:16'hABCD}, exactly two wr_en pulses, each one cycle after its low byte;
  - cpu_hold high from the cycle after A5 until DONE, then loaded=1, cpu_hold=0.
- Same frame with csum 8'h41 → both words still written, err=1, loaded=0, cpu_hold stays 1; then a good frame → loaded=1, err=0, cpu_hold=0.
- A5 04 01 (N = 1025 > 1024) → ERROR immediately, no wr_en, err=1; a following byte 8'h00 is discarded in IDLE.
- A5 00 00 00 → DONE with no writes, loaded=1.
- Asynchronous reset asserted mid-word after A5 00 03 12 34 56:
  - exactly one write (addr 0 = 16'h1234);
  - all outputs return to reset values without a clock edge;
  - a following full 3-word frame writes addresses 0..2.
- Full 1024-word frame with in_valid held continuously → last write at addr 10'h3FF, in_ready low exactly 1024 cycles, loaded=1.

Source files
------------

// File: rtl/instr_loader.sv
// Serial-byte loader: parses HEADER/LEN/data/CSUM frames into 16-bit instruction memory writes.
// Each write lands one cycle after its low byte; in_ready drops for that single WRITE cycle only.
module instr_loader #(
  parameter int         ADDR_WIDTH    = 10,
  parameter logic [7:0] HEADER        = 8'hA5,
  parameter logic       HOLD_AT_RESET = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [15:0]           wr_data,
  output logic                  cpu_hold,
  output logic                  loaded,
  output logic                  err
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LEN_H  = 4'd1,
    LEN_L  = 4'd2,
    DATA_H = 4'd3,
    DATA_L = 4'd4,
    WRITE  = 4'd5,
    CHECK  = 4'd6,
    DONE   = 4'd7,
    ERROR  = 4'd8
  } state_t;

  // One extra bit so a full-depth frame can count to 2**ADDR_WIDTH without wrapping.
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;

  state_t                state, state_n;
  logic [7:0]            len_h;
  logic [15:0]           len;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_inc;
  logic [7:0]            csum;
  logic [7:0]            hi;
  logic [15:0]           len_now;
  logic                  acc;

  assign acc       = in_valid & in_ready;
  assign len_now   = {len_h, in_data};
  assign count_inc = count + {{ADDR_WIDTH{1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (acc && in_data == HEADER) state_n = LEN_H;
      LEN_H:  if (acc) state_n = LEN_L;
      LEN_L: begin
        if (acc) begin
          if (17'(len_now) > DEPTH)  state_n = ERROR;
          else if (len_now == 16'd0) state_n = CHECK;
          else                       state_n = DATA_H;
        end
      end
      DATA_H: if (acc) state_n = DATA_L;
      DATA_L: if (acc) state_n = WRITE;
      WRITE:  state_n = (17'(count_inc) == 17'(len)) ? CHECK : DATA_H;
      CHECK:  if (acc) state_n = (in_data == csum) ? DONE : ERROR;
      DONE:   state_n = IDLE;
      ERROR:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state != WRITE);
    wr_en    = (state == WRITE);
  end

  // Frame datapath and sticky status; an in-frame HEADER byte is just data here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_h    <= 8'd0;
      len      <= 16'd0;
      count    <= '0;
      csum     <= 8'd0;
      hi       <= 8'd0;
      wr_addr  <= '0;
      wr_data  <= 16'd0;
      cpu_hold <= HOLD_AT_RESET;
      loaded   <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc && in_data == HEADER) begin
            cpu_hold <= 1'b1;
            loaded   <= 1'b0;
            err      <= 1'b0;
            csum     <= 8'd0;
            count    <= '0;
          end
        end
        LEN_H: if (acc) len_h <= in_data;
        LEN_L: if (acc) len <= len_now;
        DATA_H: begin
          if (acc) begin
            hi   <= in_data;
            csum <= csum ^ in_data;
          end
        end
        DATA_L: begin
          if (acc) begin
            csum    <= csum ^ in_data;
            wr_data <= {hi, in_data};
            wr_addr <= count[ADDR_WIDTH-1:0];
          end
        end
        WRITE: count <= count_inc;
        DONE: begin
          loaded   <= 1'b1;
          cpu_hold <= 1'b0;
        end
        ERROR: begin
          err      <= 1'b1;
          cpu_hold <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Randomised frame bench for instr_loader with a write scoreboard and frame-level status model.
module tb_instr_loader;

  localparam int         AW    = 10;
  localparam int         DEPTH = 1 << AW;
  localparam logic [7:0] HDR   = 8'hA5;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          cpu_hold;
  logic          loaded;
  logic          err;

  instr_loader #(.ADDR_WIDTH(AW), .HEADER(HDR), .HOLD_AT_RESET(1'b0)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .loaded(loaded), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [15:0] data;
  } wexp_t;

  wexp_t       sb[$];
  logic [15:0] fw[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          rdy_low = 0;
  logic [31:0] last_addr = 0;
  logic        exp_hold = 1'b0;
  logic        exp_loaded = 1'b0;
  logic        exp_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write, including its cycle.
  always @(negedge clk) begin
    if (!reset && !in_ready) rdy_low++;
    if (!reset && wr_en) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", wr_addr, wr_data);
      end else begin
        wexp_t e;
        e = sb.pop_front();
        check("wr_addr", 32'(wr_addr), e.addr);
        check("wr_data", 32'(wr_data), 32'(e.data));
        check("wr_cycle", cyc, e.cyc);
      end
      last_addr = 32'(wr_addr);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Starts and ends one time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok;
    if (gaps) idle($urandom_range(0, 2));
    in_data  = b;
    in_valid = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      if (t >= 20) begin
        vectors++;
        miscompares++;
        $display("FAIL accept_timeout: byte %0h not accepted, expected acceptance within 20 cycles", b);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_status(input string tag);
    idle(3);
    check({tag, "_loaded"}, 32'(loaded), 32'(exp_loaded));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_hold"}, 32'(cpu_hold), 32'(exp_hold));
  endtask

  // Sends HEADER, N, words from fw (MSB first), then the XOR checksum (optionally corrupted).
  task automatic send_frame(input int n, input bit corrupt, input bit gaps);
    logic [7:0] cs;
    logic [15:0] nn;
    cs = 8'h00;
    nn = 16'(n);
    send_byte(HDR, gaps);
    check("hold_after_header", 32'(cpu_hold), 32'd1);
    send_byte(nn[15:8], gaps);
    send_byte(nn[7:0], gaps);
    if (n > DEPTH) begin
      exp_err = 1'b1; exp_loaded = 1'b0; exp_hold = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      wexp_t e;
      send_byte(fw[i][15:8], gaps);
      send_byte(fw[i][7:0], gaps);
      cs = cs ^ fw[i][15:8] ^ fw[i][7:0];
      e.cyc = cyc; e.addr = 32'(i); e.data = fw[i];
      sb.push_back(e);
    end
    send_byte(corrupt ? (cs ^ 8'h01) : cs, gaps);
    if (corrupt) begin
      exp_err = 1'b1; exp_loaded = 1'b0; exp_hold = 1'b1;
    end else begin
      exp_err = 1'b0; exp_loaded = 1'b1; exp_hold = 1'b0;
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    idle(2);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_loaded", 32'(loaded), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    reset = 1'b0;
    idle(1);

    send_byte(8'h00, 1'b0);
    send_byte(8'h12, 1'b0);
    check_status("idle_bytes");
    check("idle_in_ready", 32'(in_ready), 32'd1);

    fw = '{16'h1234, 16'hABCD};
    send_frame(2, 1'b0, 1'b0);
    check_status("good2");

    send_frame(2, 1'b1, 1'b0);
    check_status("badcs");
    send_frame(2, 1'b0, 1'b1);
    check_status("recover");

    send_frame(DEPTH + 1, 1'b0, 1'b0);
    check_status("toolong");
    send_byte(8'h00, 1'b0);
    check_status("toolong_discard");

    fw = '{};
    send_frame(0, 1'b0, 1'b0);
    check_status("empty");

    for (int r = 0; r < 8; r++) begin
      int n;
      bit bad;
      n = $urandom_range(1, 6);
      bad = ($urandom_range(0, 3) == 0);
      fw = '{};
      for (int i = 0; i < n; i++) begin
        logic [15:0] w;
        w = 16'($urandom);
        if ($urandom_range(0, 3) == 0) w[15:8] = HDR;
        fw.push_back(w);
      end
      send_frame(n, bad, 1'b1);
      check_status("random");
    end

    // Abort mid-frame with async reset: only word 0 completed.
    begin
      wexp_t e;
      send_byte(HDR, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h03, 1'b0);
      send_byte(8'h12, 1'b0);
      send_byte(8'h34, 1'b0);
      e.cyc = cyc; e.addr = 0; e.data = 16'h1234;
      sb.push_back(e);
      send_byte(8'h56, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      check("abort_hold", 32'(cpu_hold), 32'd0);
      check("abort_loaded", 32'(loaded), 32'd0);
      check("abort_err", 32'(err), 32'd0);
      check("abort_wr_en", 32'(wr_en), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_wr_data", 32'(wr_data), 32'd0);
      check("abort_wr_addr", 32'(wr_addr), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_hold = 1'b0; exp_loaded = 1'b0; exp_err = 1'b0;
      fw = '{16'h0102, 16'hA5A5, 16'hFFEE};
      send_frame(3, 1'b0, 1'b0);
      check_status("after_abort");
    end

    fw = '{};
    for (int i = 0; i < DEPTH; i++) fw.push_back(16'($urandom));
    rdy_low = 0;
    send_frame(DEPTH, 1'b0, 1'b0);
    check_status("full");
    check("full_last_addr", last_addr, 32'(DEPTH - 1));
    check("full_rdy_low", rdy_low, DEPTH);

    idle(2);
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
